controlador_cafe: RTL and testbench
===================================

Name: controlador_cafe

Overview:
Sequencing controller for the coffee-machine datapath (thermoblock heater, pump, water reservoir). It handles power-up warm-up, access-code validation with lockout, drink selection latching, timed pump dispensing and reservoir accounting/refill. It drives the heater and pump enables and exports a 4-bit state code for the display/top level.

Parameters:
WARM_CYCLES, 5, heater warm-up duration in CLK cycles after power-on
CODIGO_OK, 7'b0010001, valid access code
MAX_TENT, 3, wrong codes allowed before lockout
LOCK_CYCLES, 4, lockout duration in CLK cycles
CUP_CURTO, 2, pump cycles for selecao=01 (consumes 1 unit)
CUP_LONGO, 4, pump cycles for selecao=10 (consumes 2 units)
RES_MAX, 15, full reservoir level (fits 4 bits)

Ports:
CLK  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
power  in  1  machine power switch, level
codigo  in  7  access code value
confirma  in  1  one-cycle strobe: evaluate codigo
selecao  in  2  drink select: 01 short, 10 long, 00/11 ignored
start  in  1  dispense request, level; rising edge acts
refill  in  1  reservoir refilled, level
termobloca  out  1  heater enable
bomba  out  1  pump enable
reservatorio  out  4  water level 0..RES_MAX
estado  out  4  current FSM state code

Behaviour:
- Reset (async, reset_n=0): estado=OFF, termobloca=0, bomba=0, reservatorio=RES_MAX, attempt/timer counters=0, latched selection=none, start edge register=0.
- All outputs registered; estado reflects state one cycle after the causing input edge.
- States (code): OFF 0, AQUECER 1, ESPERA_CODIGO 2, BLOQUEADO 3, ESPERA_SELECAO 4, PRONTO 5, SERVIR 6, SEM_AGUA 7.
- power=0 in any state -> OFF next cycle; bomba=0, termobloca=0, timers and attempt counter cleared, latched selection cleared; reservatorio retained. Overrides every other event, including mid-SERVIR (water already deducted is not restored).
- OFF: power=1 -> AQUECER, timer cleared.
- AQUECER: termobloca=1; after WARM_CYCLES cycles in state -> ESPERA_CODIGO. confirma ignored.
- ESPERA_CODIGO: confirma with codigo==CODIGO_OK -> ESPERA_SELECAO, attempts cleared. Wrong code -> attempts+1; reaching MAX_TENT -> BLOQUEADO.
- BLOQUEADO: confirma ignored; after LOCK_CYCLES -> ESPERA_CODIGO, attempts=0.
- ESPERA_SELECAO: selecao 01/10 -> latch, PRONTO. 00/11 stays.
- PRONTO: new valid selecao re-latches. Rising edge of start (start=1, previous sample 0): if reservatorio >= consumption -> SERVIR, reservatorio -= consumption in the same transition; else -> SEM_AGUA. Start held high never retriggers.
- SERVIR: bomba=1 for exactly CUP_CURTO/CUP_LONGO cycles, then -> ESPERA_SELECAO with selection cleared. start/selecao/confirma/refill ignored.
- SEM_AGUA: bomba=0; refill=1 -> reservatorio=RES_MAX, PRONTO (selection kept).
- refill=1 in AQUECER, ESPERA_CODIGO, BLOQUEADO, ESPERA_SELECAO, PRONTO: reservatorio=RES_MAX, no state change. Ignored in OFF and SERVIR.
- termobloca=1 in every state except OFF.
- Reservoir never underflows; start edge with insufficient water never runs the pump.

Test Plan:
- Reset with power=0 -> estado=0, reservatorio=15, bomba=0, termobloca=0; power=1 -> estado=1, termobloca=1, estado=2 after 5 cycles.
- In state 2, confirma with codigo=7'b0010011 three times -> estado=3 for 4 cycles, then estado=2. Power drop after one wrong code, then power=1 -> counter cleared (3 fresh attempts).
- Correct code 7'b0010001, selecao=10, start rising -> estado=6, bomba=1 exactly 4 cycles, reservatorio 15->13, then estado=4. Start held high causes no second dispense.
- selecao=01 then start -> bomba 2 cycles, reservatorio-1. With reservatorio=1, selecao=10 and start -> estado=7, bomba stays 0; refill=1 -> reservatorio=15, estado=5; next start edge dispenses.
- power=0 during SERVIR cycle 2 -> next cycle estado=0, bomba=0, reservatorio keeps the deducted value. Async reset_n low mid-SERVIR -> immediate full reset values.
- selecao=00/11 in state 4 -> no transition; confirma in states 1/3 -> ignored.

Source files
------------

// File: rtl/controlador_cafe.sv
`default_nettype none
// ============================================================================
// Module      : controlador_cafe
// Description : Sequencing controller for the coffee machine. It covers
//               heater warm-up, access-code checking with lockout, drink
//               selection latching, timed pump dispensing and reservoir
//               accounting/refill.
// Ports       : CLK          - system clock, rising edge
//               reset_n      - asynchronous active-low reset
//               power        - power switch (level)
//               codigo[6:0]  - access code, evaluated on confirma
//               confirma     - one-cycle strobe that evaluates codigo
//               selecao[1:0] - 01 short, 10 long, 00/11 ignored
//               start        - dispense request, acts on its rising edge
//               refill       - reservoir refilled (level)
//               termobloca   - heater enable
//               bomba        - pump enable
//               reservatorio - water level 0..RES_MAX
//               estado[3:0]  - current state code
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_cafe #(
  parameter int         WARM_CYCLES = 5,
  parameter logic [6:0] CODIGO_OK   = 7'b0010001,
  parameter int         MAX_TENT    = 3,
  parameter int         LOCK_CYCLES = 4,
  parameter int         CUP_CURTO   = 2,
  parameter int         CUP_LONGO   = 4,
  parameter int         RES_MAX     = 15
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       power,
  input  logic [6:0] codigo,
  input  logic       confirma,
  input  logic [1:0] selecao,
  input  logic       start,
  input  logic       refill,
  output logic       termobloca,
  output logic       bomba,
  output logic [3:0] reservatorio,
  output logic [3:0] estado
);

  localparam logic [3:0] S_OFF            = 4'd0;
  localparam logic [3:0] S_AQUECER        = 4'd1;
  localparam logic [3:0] S_ESPERA_CODIGO  = 4'd2;
  localparam logic [3:0] S_BLOQUEADO      = 4'd3;
  localparam logic [3:0] S_ESPERA_SELECAO = 4'd4;
  localparam logic [3:0] S_PRONTO         = 4'd5;
  localparam logic [3:0] S_SERVIR         = 4'd6;
  localparam logic [3:0] S_SEM_AGUA       = 4'd7;

  // Timers count the cycles already spent in the state; the exit happens on
  // the edge where the count reaches duration-1.
  localparam logic [7:0] c_warm_last  = 8'(WARM_CYCLES - 1);
  localparam logic [7:0] c_lock_last  = 8'(LOCK_CYCLES - 1);
  localparam logic [7:0] c_curto_last = 8'(CUP_CURTO - 1);
  localparam logic [7:0] c_longo_last = 8'(CUP_LONGO - 1);
  localparam logic [3:0] c_tent_last  = 4'(MAX_TENT - 1);
  localparam logic [3:0] c_res_max    = 4'(RES_MAX);

  logic [7:0] r_timer;
  logic [3:0] r_att;
  logic [1:0] r_sel;
  logic       r_start_q;

  logic [3:0] w_nxt_state;
  logic [7:0] w_nxt_timer;
  logic [3:0] w_nxt_att;
  logic [1:0] w_nxt_sel;
  logic [3:0] w_nxt_res;
  logic       w_nxt_bomba;
  logic       w_start_edge;
  logic       w_sel_valid;
  logic [3:0] w_cons;
  logic [7:0] w_cup_last;

  assign w_start_edge = start & ~r_start_q;
  assign w_sel_valid  = (selecao == 2'b01) || (selecao == 2'b10);
  assign w_cons       = (r_sel == 2'b10) ? 4'd2 : ((r_sel == 2'b01) ? 4'd1 : 4'd0);
  assign w_cup_last   = (r_sel == 2'b10) ? c_longo_last : c_curto_last;

  always_comb begin
    w_nxt_state = estado;
    w_nxt_timer = r_timer;
    w_nxt_att   = r_att;
    w_nxt_sel   = r_sel;
    w_nxt_res   = reservatorio;
    w_nxt_bomba = 1'b0;
    if (!power) begin
      // Power loss wins over everything; water already deducted stays deducted.
      w_nxt_state = S_OFF;
      w_nxt_timer = 8'd0;
      w_nxt_att   = 4'd0;
      w_nxt_sel   = 2'b00;
    end else begin
      case (estado)
        S_OFF: begin
          w_nxt_state = S_AQUECER;
          w_nxt_timer = 8'd0;
        end
        S_AQUECER: begin
          if (refill) w_nxt_res = c_res_max;
          if (r_timer == c_warm_last) begin
            w_nxt_state = S_ESPERA_CODIGO;
            w_nxt_timer = 8'd0;
          end else begin
            w_nxt_timer = r_timer + 8'd1;
          end
        end
        S_ESPERA_CODIGO: begin
          if (refill) w_nxt_res = c_res_max;
          if (confirma) begin
            if (codigo == CODIGO_OK) begin
              w_nxt_state = S_ESPERA_SELECAO;
              w_nxt_att   = 4'd0;
            end else begin
              w_nxt_att = r_att + 4'd1;
              if (r_att == c_tent_last) begin
                w_nxt_state = S_BLOQUEADO;
                w_nxt_timer = 8'd0;
              end
            end
          end
        end
        S_BLOQUEADO: begin
          if (refill) w_nxt_res = c_res_max;
          if (r_timer == c_lock_last) begin
            w_nxt_state = S_ESPERA_CODIGO;
            w_nxt_timer = 8'd0;
            w_nxt_att   = 4'd0;
          end else begin
            w_nxt_timer = r_timer + 8'd1;
          end
        end
        S_ESPERA_SELECAO: begin
          if (refill) w_nxt_res = c_res_max;
          if (w_sel_valid) begin
            w_nxt_sel   = selecao;
            w_nxt_state = S_PRONTO;
          end
        end
        S_PRONTO: begin
          // A start edge is judged against the selection already latched,
          // so a simultaneous new selection does not re-latch.
          if (w_start_edge) begin
            if (reservatorio >= w_cons) begin
              w_nxt_state = S_SERVIR;
              w_nxt_res   = reservatorio - w_cons;
              w_nxt_bomba = 1'b1;
              w_nxt_timer = 8'd0;
            end else begin
              w_nxt_state = S_SEM_AGUA;
            end
          end else begin
            if (w_sel_valid) w_nxt_sel = selecao;
            if (refill) w_nxt_res = c_res_max;
          end
        end
        S_SERVIR: begin
          if (r_timer == w_cup_last) begin
            w_nxt_state = S_ESPERA_SELECAO;
            w_nxt_sel   = 2'b00;
            w_nxt_timer = 8'd0;
          end else begin
            w_nxt_timer = r_timer + 8'd1;
            w_nxt_bomba = 1'b1;
          end
        end
        S_SEM_AGUA: begin
          if (refill) begin
            w_nxt_res   = c_res_max;
            w_nxt_state = S_PRONTO;
          end
        end
        default: begin
          w_nxt_state = S_OFF;
          w_nxt_timer = 8'd0;
          w_nxt_att   = 4'd0;
          w_nxt_sel   = 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      estado       <= S_OFF;
      termobloca   <= 1'b0;
      bomba        <= 1'b0;
      reservatorio <= c_res_max;
      r_timer      <= 8'd0;
      r_att        <= 4'd0;
      r_sel        <= 2'b00;
      r_start_q    <= 1'b0;
    end else begin
      estado       <= w_nxt_state;
      termobloca   <= (w_nxt_state != S_OFF);
      bomba        <= w_nxt_bomba;
      reservatorio <= w_nxt_res;
      r_timer      <= w_nxt_timer;
      r_att        <= w_nxt_att;
      r_sel        <= w_nxt_sel;
      r_start_q    <= start;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controlador_cafe.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_cafe
// Description : Directed self-checking bench for controlador_cafe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_cafe;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic       power;
  logic [6:0] codigo;
  logic       confirma;
  logic [1:0] selecao;
  logic       start;
  logic       refill;
  logic       termobloca;
  logic       bomba;
  logic [3:0] reservatorio;
  logic [3:0] estado;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] c_ok  = 7'b0010001;
  localparam logic [6:0] c_bad = 7'b0010011;

  controlador_cafe dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .power        (power),
    .codigo       (codigo),
    .confirma     (confirma),
    .selecao      (selecao),
    .start        (start),
    .refill       (refill),
    .termobloca   (termobloca),
    .bomba        (bomba),
    .reservatorio (reservatorio),
    .estado       (estado)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic pulse_code(input logic [6:0] c);
    codigo   = c;
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
  endtask

  // Select, raise start for one cycle, then wait out n pump cycles.
  task automatic serve(input logic [1:0] s, input int n);
    selecao = s;
    tick();
    selecao = 2'b00;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic power_up_to_code();
    power = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    reset_n = 1'b0; power = 1'b0; codigo = 7'd0; confirma = 1'b0;
    selecao = 2'b00; start = 1'b0; refill = 1'b0;
    #12;
    chk("rst_estado", 8'(estado), 8'd0);
    chk("rst_res", 8'(reservatorio), 8'd15);
    chk("rst_bomba", 8'(bomba), 8'd0);
    chk("rst_termo", 8'(termobloca), 8'd0);
    reset_n = 1'b1;
    tick();
    chk("off_hold", 8'(estado), 8'd0);

    // Warm-up: 5 cycles in AQUECER, confirma ignored there
    power = 1'b1;
    tick();
    chk("aquecer", 8'(estado), 8'd1);
    chk("aquecer_termo", 8'(termobloca), 8'd1);
    pulse_code(c_ok);
    chk("aquecer_conf_ign", 8'(estado), 8'd1);
    repeat (3) tick();
    chk("aquecer_5th", 8'(estado), 8'd1);
    tick();
    chk("espera_codigo", 8'(estado), 8'd2);

    // One wrong code, then power cycle clears the attempt counter
    pulse_code(c_bad);
    chk("wrong1", 8'(estado), 8'd2);
    power = 1'b0;
    tick();
    chk("pwr_off", 8'(estado), 8'd0);
    chk("pwr_off_termo", 8'(termobloca), 8'd0);
    power_up_to_code();
    chk("back_code", 8'(estado), 8'd2);
    pulse_code(c_bad);
    pulse_code(c_bad);
    chk("two_wrong", 8'(estado), 8'd2);
    pulse_code(c_bad);
    chk("locked", 8'(estado), 8'd3);
    pulse_code(c_ok);
    chk("lock_conf_ign", 8'(estado), 8'd3);
    tick();
    tick();
    chk("lock_4th", 8'(estado), 8'd3);
    tick();
    chk("unlock", 8'(estado), 8'd2);

    // Correct code and selection handling
    pulse_code(c_ok);
    chk("code_ok", 8'(estado), 8'd4);
    selecao = 2'b00;
    tick();
    chk("sel00", 8'(estado), 8'd4);
    selecao = 2'b11;
    tick();
    chk("sel11", 8'(estado), 8'd4);

    // Long dispense: 4 pump cycles, 15 -> 13
    selecao = 2'b10;
    tick();
    chk("pronto", 8'(estado), 8'd5);
    selecao = 2'b00;
    start = 1'b1;
    tick();
    chk("servir", 8'(estado), 8'd6);
    chk("servir_bomba1", 8'(bomba), 8'd1);
    chk("servir_res", 8'(reservatorio), 8'd13);
    tick(); tick(); tick();
    chk("servir_bomba4", 8'(bomba), 8'd1);
    tick();
    chk("servir_done", 8'(estado), 8'd4);
    chk("servir_done_bomba", 8'(bomba), 8'd0);
    // start still high: no second dispense
    selecao = 2'b10;
    tick();
    selecao = 2'b00;
    tick(); tick();
    chk("held_start_st", 8'(estado), 8'd5);
    chk("held_start_res", 8'(reservatorio), 8'd13);
    start = 1'b0;
    tick();

    // Short dispense: re-latch in PRONTO, 2 pump cycles, 13 -> 12
    selecao = 2'b01;
    tick();
    selecao = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("short_res", 8'(reservatorio), 8'd12);
    tick();
    chk("short_bomba2", 8'(bomba), 8'd1);
    tick();
    chk("short_done", 8'(estado), 8'd4);
    chk("short_done_bomba", 8'(bomba), 8'd0);

    // Drain to 1: five long (12->2) then one short (2->1)
    repeat (5) serve(2'b10, 4);
    serve(2'b01, 2);
    chk("drained_res", 8'(reservatorio), 8'd1);
    chk("drained_st", 8'(estado), 8'd4);

    // Insufficient water for a long cup
    selecao = 2'b10;
    tick();
    selecao = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sem_agua", 8'(estado), 8'd7);
    chk("sem_agua_bomba", 8'(bomba), 8'd0);
    chk("sem_agua_res", 8'(reservatorio), 8'd1);
    tick();
    chk("sem_agua_hold", 8'(estado), 8'd7);
    refill = 1'b1;
    tick();
    refill = 1'b0;
    chk("refill_res", 8'(reservatorio), 8'd15);
    chk("refill_st", 8'(estado), 8'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("after_refill_st", 8'(estado), 8'd6);
    chk("after_refill_res", 8'(reservatorio), 8'd13);

    // Power loss during the second pump cycle
    tick();
    power = 1'b0;
    tick();
    chk("pwr_mid_st", 8'(estado), 8'd0);
    chk("pwr_mid_bomba", 8'(bomba), 8'd0);
    chk("pwr_mid_res", 8'(reservatorio), 8'd13);

    // Async reset in the middle of a dispense
    power_up_to_code();
    pulse_code(c_ok);
    selecao = 2'b01;
    tick();
    selecao = 2'b00;
    start = 1'b1;
    tick();
    chk("pre_rst_st", 8'(estado), 8'd6);
    chk("pre_rst_res", 8'(reservatorio), 8'd12);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_st", 8'(estado), 8'd0);
    chk("arst_res", 8'(reservatorio), 8'd15);
    chk("arst_bomba", 8'(bomba), 8'd0);
    chk("arst_termo", 8'(termobloca), 8'd0);
    start = 1'b0;
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
